// File: rtl/insight_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : insight_trace_pkg
//  Description : Shared types and default sizes for the commit-trace merger.
//  Revision    : 1.0 - initial release
// ============================================================================
package insight_trace_pkg;

  localparam int c_TRACE_W = 128;
  localparam int c_DEPTH   = 8;
  localparam int c_CNT_W   = 16;

  // One packed commit record (address, instruction, privilege, cause).
  typedef logic [c_TRACE_W-1:0] trace_rec_t;

  // FIFO entry: record plus "groups were dropped before me" marker.
  typedef struct packed {
    logic       gap;
    trace_rec_t rec;
  } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/insight_trace_fifo2w1r.sv
`default_nettype none
// ============================================================================
//  Module      : insight_trace_fifo2w1r
//  Description : Circular buffer accepting up to two writes and one read per
//                cycle. The caller guarantees writes never exceed free space.
//  Revision    : 1.0 - initial release
// ============================================================================
module insight_trace_fifo2w1r
  import insight_trace_pkg::*;
#(
  parameter  int WIDTH = c_TRACE_W + 1,
  parameter  int DEPTH = c_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       wr_cnt,
  input  logic [WIDTH-1:0] wr_data0,
  input  logic [WIDTH-1:0] wr_data1,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [PTR_W-1:0] w_wr_ptr1;

  assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);

  // Storage: the older record lands at the write pointer, the younger after it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (!flush) begin
      if (wr_cnt != 2'd0) r_mem[r_wr_ptr] <= wr_data0;
      if (wr_cnt == 2'd2) r_mem[w_wr_ptr1] <= wr_data1;
    end
  end

  // Pointers wrap naturally modulo DEPTH; occupancy is tracked on its own.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(wr_cnt);
      r_rd_ptr <= r_rd_ptr + PTR_W'(rd_en);
      r_level  <= r_level + LVL_W'(wr_cnt) - LVL_W'(rd_en);
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign level   = r_level;

endmodule
`default_nettype wire

// File: rtl/insight_trace_merge.sv
`default_nettype none
// ============================================================================
//  Module      : insight_trace_merge
//  Description : Merges the two commit-trace lanes of hart 0 into one in-order
//                valid/ready stream. Groups that do not fit are dropped whole,
//                counted, and the next surviving record is flagged with a gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module insight_trace_merge
  import insight_trace_pkg::*;
#(
  parameter  int TRACE_W = c_TRACE_W,
  parameter  int DEPTH   = c_DEPTH,
  parameter  int CNT_W   = c_CNT_W,
  localparam int LVL_W   = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               flush,
  input  logic               clear_stats,
  input  logic               in0_valid,
  input  logic [TRACE_W-1:0] in0_data,
  input  logic               in1_valid,
  input  logic [TRACE_W-1:0] in1_data,
  output logic               out_valid,
  output logic [TRACE_W-1:0] out_data,
  output logic               out_gap,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   drop_count,
  output logic               overflow,
  output logic [LVL_W-1:0]   level
);

  localparam int c_SUM_W = CNT_W + 1;

  logic               r_gap_pending;
  logic [CNT_W-1:0]   r_drop_count;
  logic               r_overflow;

  logic [1:0]         w_n;
  logic [LVL_W-1:0]   w_level;
  logic [LVL_W-1:0]   w_free;
  logic               w_drop;
  logic [1:0]         w_wr_cnt;
  logic               w_out_valid;
  logic               w_rd;
  logic [TRACE_W:0]   w_e0;
  logic [TRACE_W:0]   w_e1;
  logic [TRACE_W:0]   w_head;
  logic [c_SUM_W-1:0] w_sum;
  logic [CNT_W-1:0]   w_cnt_sat;

  // Group size; a disabled cycle presents an empty group.
  assign w_n = enable ? ({1'b0, in0_valid} + {1'b0, in1_valid}) : 2'd0;

  // Space is judged on pre-edge occupancy; a same-cycle dequeue does not help.
  assign w_free   = LVL_W'(DEPTH) - w_level;
  assign w_drop   = LVL_W'(w_n) > w_free;
  assign w_wr_cnt = w_drop ? 2'd0 : w_n;

  // Compact the group: the oldest valid record always goes first and is the
  // only one that can carry the gap marker.
  assign w_e0 = {r_gap_pending, (in0_valid ? in0_data : in1_data)};
  assign w_e1 = {1'b0, in1_data};

  assign w_out_valid = (w_level != '0);
  assign w_rd        = w_out_valid & out_ready;

  insight_trace_fifo2w1r #(
    .WIDTH (TRACE_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .wr_cnt   (w_wr_cnt),
    .wr_data0 (w_e0),
    .wr_data1 (w_e1),
    .rd_en    (w_rd),
    .rd_data  (w_head),
    .level    (w_level)
  );

  // Gap marker is armed by a drop and consumed by the next accepted group.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_gap_pending <= 1'b0;
    end else if (flush) begin
      r_gap_pending <= 1'b0;
    end else if (w_drop) begin
      r_gap_pending <= 1'b1;
    end else if (w_wr_cnt != 2'd0) begin
      r_gap_pending <= 1'b0;
    end
  end

  assign w_sum     = {1'b0, r_drop_count} + c_SUM_W'(w_n);
  assign w_cnt_sat = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

  // Drop statistics; an explicit clear beats a simultaneous drop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else if (clear_stats) begin
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else if (w_drop) begin
      r_drop_count <= w_cnt_sat;
      r_overflow   <= 1'b1;
    end
  end

  assign out_valid  = w_out_valid;
  assign out_data   = w_head[TRACE_W-1:0];
  assign out_gap    = w_head[TRACE_W] & w_out_valid;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;
  assign level      = w_level;

endmodule
`default_nettype wire

// File: tb/tb_insight_trace_merge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_insight_trace_merge
//  Description : Self-checking bench: directed scenarios plus randomized
//                traffic compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_insight_trace_merge;

  localparam int TW      = 128;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int LVL_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable, flush, clear_stats;
  logic             in0_valid, in1_valid, out_ready;
  logic [TW-1:0]    in0_data, in1_data, out_data;
  logic             out_valid, out_gap, overflow;
  logic [CNT_W-1:0] drop_count;
  logic [LVL_W-1:0] level;

  always #5 clock = ~clock;

  insight_trace_merge #(
    .TRACE_W (TW),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .flush       (flush),
    .clear_stats (clear_stats),
    .in0_valid   (in0_valid),
    .in0_data    (in0_data),
    .in1_valid   (in1_valid),
    .in1_data    (in1_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_gap     (out_gap),
    .out_ready   (out_ready),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .level       (level)
  );

  typedef struct packed {
    logic          gap;
    logic [TW-1:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_drops;
  bit   m_ovf;
  bit   m_gp;
  int   n_checks;
  int   n_fails;

  task automatic check(input string tag, input logic [TW:0] obs, input logic [TW:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
    m_gp    = 1'b0;
  endtask

  // Reference behaviour for one rising edge, from the current input values.
  task automatic model_step();
    int n, sz;
    bit drop, g;
    n    = enable ? (int'(in0_valid) + int'(in1_valid)) : 0;
    sz   = mq.size();
    drop = n > (DEPTH - sz);
    if (clear_stats) begin
      m_drops = 0;
      m_ovf   = 1'b0;
    end else if (drop) begin
      m_drops = (m_drops + n > CNT_MAX) ? CNT_MAX : m_drops + n;
      m_ovf   = 1'b1;
    end
    if (flush) begin
      mq.delete();
      m_gp = 1'b0;
    end else begin
      if (out_ready && sz > 0) void'(mq.pop_front());
      if (drop) begin
        m_gp = 1'b1;
      end else if (n > 0) begin
        g = m_gp;
        if (in0_valid) begin
          mq.push_back({g, in0_data});
          g = 1'b0;
        end
        if (in1_valid) mq.push_back({g, in1_data});
        m_gp = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("out_valid", out_valid, mq.size() > 0);
    check("level", level, mq.size());
    check("drop_count", drop_count, m_drops);
    check("overflow", overflow, m_ovf);
    if (mq.size() > 0) begin
      check("out_data", out_data, mq[0].data);
      check("out_gap", out_gap, mq[0].gap);
    end else begin
      check("out_gap_idle", out_gap, 1'b0);
    end
  endtask

  // Drive one cycle of inputs just after a falling edge, apply the model at
  // the rising edge, and compare on the next falling edge.
  task automatic cycle(input bit v0, input bit v1, input bit rdy,
                       input bit fl, input bit clr, input bit en);
    in0_valid   = v0;
    in1_valid   = v1;
    in0_data    = rnd128();
    in1_data    = rnd128();
    out_ready   = rdy;
    flush       = fl;
    clear_stats = clr;
    enable      = en;
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(input int k, input bit rdy);
    for (int i = 0; i < k; i++) cycle(0, 0, rdy, 0, 0, 1);
  endtask

  initial begin
    int rp;
    n_checks = 0;
    n_fails  = 0;
    model_reset();
    enable = 1'b1; flush = 1'b0; clear_stats = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    in0_data = '0; in1_data = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_gap", out_gap, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_drop_count", drop_count, '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_level", level, '0);
    reset = 1'b1;

    // Single lane, consecutive records, sink always ready
    cycle(1, 0, 1, 0, 0, 1);
    cycle(1, 0, 1, 0, 0, 1);
    idle(2, 1);

    // Dual commit ordering
    cycle(1, 1, 1, 0, 0, 1);
    idle(3, 1);

    // Lane 1 alone, and disabled lanes
    cycle(0, 1, 1, 0, 0, 1);
    cycle(1, 1, 1, 0, 0, 0);
    idle(2, 1);

    // Overflow and gap marking
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 1);
    check("ovf_full_level", level, 8);
    cycle(1, 1, 0, 0, 0, 1);
    check("ovf_drop_count", drop_count, 2);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_level_held", level, 8);
    idle(8, 1);
    cycle(1, 0, 0, 0, 0, 1);
    check("gap_first", out_gap, 1'b1);
    cycle(1, 0, 1, 0, 0, 1);
    check("gap_next", out_gap, 1'b0);
    idle(3, 1);

    // Full boundary at level 7
    cycle(0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 1);
    check("bnd_dual_drop", drop_count, 2);
    check("bnd_level7", level, 7);
    cycle(0, 1, 0, 0, 0, 1);
    check("bnd_single_ok", level, 8);
    idle(9, 1);

    // Flush with concurrent enqueue
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 1, 1, 1, 0, 1);
    check("flush_level", level, 0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_stats", drop_count, 2);

    // Clear wins over a simultaneous drop
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 1, 1);
    check("clr_drop_count", drop_count, 0);
    check("clr_overflow", overflow, 1'b0);

    // Saturation
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 0, 1);
    check("sat_drop_count", drop_count, 15);
    cycle(0, 0, 0, 1, 1, 1);

    // Randomized traffic with varying sink pressure
    for (int seg = 0; seg < 30; seg++) begin
      case (seg % 4)
        0:       rp = 0;
        1:       rp = 30;
        2:       rp = 70;
        default: rp = 100;
      endcase
      for (int i = 0; i < 100; i++) begin
        cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
              $urandom_range(0, 99) < rp, $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 95);
      end
    end

    // Reset asserted mid-burst, between clock edges
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_gap", out_gap, 1'b0);
    check("arst_out_data", out_data, '0);
    check("arst_drop_count", drop_count, '0);
    check("arst_overflow", overflow, 1'b0);
    check("arst_level", level, '0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    cycle(1, 1, 1, 0, 0, 1);
    idle(3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/insight_trace_merge.md
# insight_trace_merge

Merges the two per-cycle commit-trace lanes of hart 0 into one in-order, single-lane trace stream with valid/ready flow control. Sits between the core's two commit trace ports and a single-lane trace sink (encoder, funnel or debug buffer). Absorbs dual-commit bursts in a small FIFO. On overflow it drops whole commit groups, counts them, and marks the next surviving entry so the sink can resynchronise.

## Interface
- `TRACE_W`, 128: width of one packed commit record (address, instruction, privilege, exception/cause).
- `DEPTH`, 8: FIFO entries; power of two, minimum 4.
- `CNT_W`, 16: width of the drop counter.

- `clock`  in  1  sole clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-low reset: asserting (low) clears all state immediately; deassertion is synchronous to `clock` upstream.
- `enable`  in  1  when low, lane inputs are ignored and are not counted as drops.
- `flush`  in  1  synchronous clear of FIFO contents and the pending-gap flag.
- `clear_stats`  in  1  synchronous clear of `drop_count` and `overflow`.
- `in0_valid`  in  1  lane 0 commit valid (older instruction).
- `in0_data`  in  TRACE_W  lane 0 record.
- `in1_valid`  in  1  lane 1 commit valid (younger instruction).
- `in1_data`  in  TRACE_W  lane 1 record.
- `out_valid`  out  1  output entry available.
- `out_data`  out  TRACE_W  head record.
- `out_gap`  out  1  one or more commit groups were dropped immediately before this entry.
- `out_ready`  in  1  sink accepts the head entry.
- `drop_count`  out  CNT_W  number of dropped records; saturates at all-ones.
- `overflow`  out  1  sticky flag; set on any drop.
- `level`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Group size per cycle: n = in0_valid + in1_valid (0..2), gated by `enable`.
- Ordering:
  - When both lanes are valid, lane 0 is written before lane 1.
  - When only lane 1 is valid, it is written as a single entry.
- Space check:
  - free = DEPTH − level, where level is the pre-edge value. A dequeue in the same cycle does not add space.
  - If n ≤ free, all n records are enqueued.
  - Otherwise the whole group is dropped: nothing is written, `drop_count` += n (saturating), `overflow` is set, and `gap_pending` is set.
- Gap marking:
  - Each entry stores a gap bit alongside its record.
  - The first record enqueued while `gap_pending` = 1 carries gap = 1, and `gap_pending` clears in that same cycle.
  - With two records in that group, only the lane 0 record carries the gap bit.
- Dequeue: occurs when out_valid && out_ready; the head advances by one.
- Pointers: read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `level` is tracked separately.
- Flush:
  - Empties the FIFO and clears `gap_pending`.
  - Any enqueue or dequeue in the same cycle is discarded.
  - `drop_count` and `overflow` are unaffected.
- `clear_stats` together with a drop in the same cycle: the clear wins, and `drop_count` and `overflow` are 0 after the edge.

## Timing
- Reset values: out_valid 0, out_gap 0, out_data 0, drop_count 0, overflow 0, level 0, pointers 0, gap_pending 0.
- Latency: a record enqueued at edge N is visible at the output (`out_valid`, `out_data`, `out_gap`) after edge N; no combinational path exists from inputs to outputs.
- Throughput:
  - 2 records per cycle in, 1 per cycle out.
  - A sustained dual commit fills the FIFO at a net rate of +1 per cycle.
- `out_valid` is asserted exactly when level > 0.
- `out_data` is held stable while out_valid && !out_ready.
- Full boundary: at level = DEPTH−1, a single-record group is accepted and a two-record group is dropped.
- Reset asserted mid-stream: all contents are lost and outputs return to their reset values immediately.

## Structure
- Shared package `insight_trace_pkg`:
  - `trace_rec_t` (packed TRACE_W record).
  - `trace_entry_t` (record plus gap bit).
  - DEPTH and CNT_W defaults.
- Sub-module `insight_trace_fifo2w1r`: 2-write/1-read circular buffer with pointers and level. The top level holds the space-check, gap and statistics logic.

## Test plan
- Single lane, DEPTH=8, out_ready held high: in0 records A then B on consecutive cycles → output A one cycle after its write, then B; level never exceeds 1.
- Dual commit ordering: in0=C and in1=D in the same cycle, out_ready high → output C, then D on the next cycle.
- Overflow:
  - out_ready low; 4 dual groups fill level to 8.
  - A 5th dual group → dropped: drop_count=2, overflow=1, level stays 8.
  - Drain, then enqueue E → E is output with out_gap=1; the following entry has out_gap=0.
- Boundary: level=7, out_ready low, dual group → dropped (drop_count +2); single group at level=7 → accepted, level=8.
- Flush and stats:
  - flush at level=5 with a concurrent enqueue → level=0 and out_valid=0 the next cycle; drop_count is unchanged.
  - clear_stats in the same cycle as a drop → drop_count=0, overflow=0.
- Saturation and reset:
  - CNT_W=4, force 10 dual drops → drop_count=15.
  - Assert reset mid-burst → all outputs return to 0 asynchronously.
